// File: rtl/jvs_pkg.sv
// Shared JVS framing constants, transmit state encoding and escape test,
// common to the TX framer and the RX deframer.
package jvs_pkg;

  localparam logic [7:0] JVS_SYNC = 8'hE0;
  localparam logic [7:0] JVS_MARK = 8'hD0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_NODE = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_SUM  = 3'd5,
    ST_ESC  = 3'd6
  } jvs_tx_state_t;

  // Values that would be mistaken for SYNC or MARK on the line
  function automatic logic jvs_needs_esc(input logic [7:0] b);
    return (b == JVS_SYNC) || (b == JVS_MARK);
  endfunction

endpackage

// File: rtl/jvs_tx_framer.sv
// JVS packet framer: wraps a raw payload stream with SYNC/NODE/LEN/SUM and
// byte stuffing, and feeds the UART transmitter one byte at a time.
module jvs_tx_framer
  import jvs_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 254
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_node,
  input  logic [7:0] i_len,
  output logic       o_start_ready,
  input  logic       i_pl_valid,
  input  logic [7:0] i_pl_data,
  output logic       o_pl_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  // The state names the field still owed to the line; it advances on the
  // handshake of that field, and the field is loaded in the empty-slot cycle.
  jvs_tx_state_t r_state, r_ret;
  logic          r_vld, r_esc_sent, r_done, r_err;
  logic [7:0]    r_data, r_node, r_len, r_cnt, r_sum, r_esc;

  logic          w_load, w_hs, w_len_ok;
  logic [7:0]    w_val;
  jvs_tx_state_t w_after, w_succ;

  function automatic jvs_tx_state_t next_field(input jvs_tx_state_t st,
                                               input logic [7:0] cnt);
    case (st)
      ST_SYNC: return ST_NODE;
      ST_NODE: return ST_LEN;
      ST_LEN:  return ST_DATA;
      ST_DATA: return (cnt == 8'd0) ? ST_SUM : ST_DATA;
      default: return ST_IDLE;
    endcase
  endfunction

  always_comb begin
    w_load = 1'b0;
    w_val  = 8'h00;
    if (!r_vld) begin
      case (r_state)
        ST_NODE: begin w_load = 1'b1;       w_val = r_node;         end
        ST_LEN:  begin w_load = 1'b1;       w_val = r_len + 8'd1;   end
        ST_DATA: begin w_load = i_pl_valid; w_val = i_pl_data;      end
        ST_SUM:  begin w_load = 1'b1;       w_val = r_sum;          end
        default: ;
      endcase
    end
  end

  assign w_hs     = r_vld && i_tx_ready;
  assign w_len_ok = (i_len != 8'd0) && (32'(i_len) <= MAX_PAYLOAD);
  assign w_after  = (r_state == ST_ESC) ? r_ret : r_state;
  assign w_succ   = next_field(w_after, r_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ret      <= ST_IDLE;
      r_vld      <= 1'b0;
      r_esc_sent <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_data     <= 8'h00;
      r_node     <= 8'h00;
      r_len      <= 8'h00;
      r_cnt      <= 8'h00;
      r_sum      <= 8'h00;
      r_esc      <= 8'h00;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (i_start) begin
          if (w_len_ok) begin
            r_node  <= i_node;
            r_len   <= i_len;
            r_cnt   <= i_len;
            r_sum   <= 8'h00;
            r_vld   <= 1'b1;
            r_data  <= JVS_SYNC;
            r_state <= ST_SYNC;
          end else begin
            r_err <= 1'b1;
          end
        end
      end else if (w_hs) begin
        r_vld <= 1'b0;
        // A MARK handshake keeps us in ESC; the escaped value completes the field
        if (r_state != ST_ESC || r_esc_sent) begin
          r_state    <= w_succ;
          r_esc_sent <= 1'b0;
          if (w_after == ST_SUM) r_done <= 1'b1;
        end
      end else if (!r_vld) begin
        if (r_state == ST_ESC) begin
          r_vld      <= 1'b1;
          r_data     <= r_esc;
          r_esc_sent <= 1'b1;
        end else if (w_load) begin
          r_vld <= 1'b1;
          if (r_state != ST_SUM) r_sum <= r_sum + w_val;
          if (r_state == ST_DATA) r_cnt <= r_cnt - 8'd1;
          if (jvs_needs_esc(w_val)) begin
            r_data  <= JVS_MARK;
            r_esc   <= w_val - 8'd1;
            r_ret   <= r_state;
            r_state <= ST_ESC;
          end else begin
            r_data <= w_val;
          end
        end
      end
    end
  end

  assign o_start_ready = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_pl_ready    = (r_state == ST_DATA) && !r_vld;
  assign o_tx_valid    = r_vld;
  assign o_tx_data     = r_data;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_jvs_tx_framer.sv
// Self-checking bench for jvs_tx_framer: a packet-level model predicts the
// line byte stream, and a monitor checks every cycle against it.
module tb_jvs_tx_framer;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_node = 8'h00;
  logic [7:0] i_len = 8'h00;
  logic       o_start_ready;
  logic       i_pl_valid = 1'b0;
  logic [7:0] i_pl_data = 8'h00;
  logic       o_pl_ready;
  logic       o_tx_valid;
  logic [7:0] o_tx_data;
  logic       i_tx_ready = 1'b1;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  jvs_tx_framer #(.MAX_PAYLOAD(254)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_node(i_node), .i_len(i_len),
    .o_start_ready(o_start_ready),
    .i_pl_valid(i_pl_valid), .i_pl_data(i_pl_data), .o_pl_ready(o_pl_ready),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bq_t  exp_q;
  bq_t  cap_q;
  int   done_cnt = 0;
  int   pop_cnt = 0;
  logic err_exp = 1'b0;
  logic prev_hs = 1'b0, prev_stall = 1'b0, done_exp = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] lit_basic  [6] = '{8'hE0, 8'h01, 8'h03, 8'h10, 8'h20, 8'h34};
  logic [7:0] lit_esc    [6] = '{8'hE0, 8'h01, 8'h02, 8'hD0, 8'hDF, 8'hE3};
  logic [7:0] lit_sumesc [6] = '{8'hE0, 8'h01, 8'h02, 8'hCD, 8'hD0, 8'hCF};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Packet-level model: the unescaped field list, its wrapping sum, then stuffing
  function automatic bq_t model_pkt(input logic [7:0] node, input bq_t pl);
    bq_t r, v;
    logic [7:0] s;
    s = 8'h00;
    v.push_back(node);
    v.push_back(8'(pl.size() + 1));
    foreach (pl[i]) v.push_back(pl[i]);
    foreach (v[i]) s = s + v[i];
    v.push_back(s);
    r.push_back(8'hE0);
    foreach (v[i]) begin
      if (v[i] == 8'hE0 || v[i] == 8'hD0) begin
        r.push_back(8'hD0);
        r.push_back(v[i] - 8'd1);
      end else begin
        r.push_back(v[i]);
      end
    end
    return r;
  endfunction

  task automatic cmp6(input string nm, input bq_t got, input logic [7:0] l [6]);
    chk($sformatf("%s_len", nm), got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk($sformatf("%s_b%0d", nm, i), got[i], l[i]);
  endtask

  // Per-cycle monitor, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hs = 1'b0; prev_stall = 1'b0; done_exp = 1'b0;
      end else begin
        chk("done", o_done, done_exp);
        if (o_done) done_cnt++;
        if (done_exp) chk("idle_after_done", o_start_ready, 1);
        chk("err", o_err, err_exp);
        if (prev_hs) chk("gap_after_hs", o_tx_valid, 0);
        if (prev_stall) begin
          chk("hold_valid", o_tx_valid, 1);
          chk("hold_data", o_tx_data, prev_data);
        end
        done_exp = 1'b0;
        if (o_tx_valid && i_tx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_byte: got %02h, expected no byte", o_tx_data);
          end else begin
            chk("line_byte", o_tx_data, exp_q.pop_front());
            if (exp_q.size() == 0) done_exp = 1'b1;
          end
          cap_q.push_back(o_tx_data);
          pop_cnt++;
        end
        prev_hs    = o_tx_valid && i_tx_ready;
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
      end
    end
  end

  // Called just after a rising edge; returns just after a rising edge
  task automatic send_pkt(input logic [7:0] node, input bq_t pl, input bit rnd_rdy,
                          input bit gaps, input bit poke, input int stop_after);
    int   base, pbase, idx;
    logic take;
    bq_t  m;
    base = done_cnt; pbase = pop_cnt; idx = 0;
    m = model_pkt(node, pl);
    foreach (m[i]) exp_q.push_back(m[i]);
    cap_q.delete();
    chk("start_ready_pre", o_start_ready, 1);
    i_start = 1'b1; i_node = node; i_len = 8'(pl.size());
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_c1", o_busy, 1);
    chk("start_ready_c1", o_start_ready, 0);
    chk("sync_c1", {o_tx_valid, o_tx_data}, {1'b1, 8'hE0});
    for (int c = 0; c < 3000; c++) begin
      if (done_cnt != base) break;
      if (stop_after != 0 && pop_cnt - pbase >= stop_after) break;
      i_pl_valid = (idx < pl.size()) ? (gaps ? ($urandom_range(0, 2) != 0) : 1'b1) : 1'b1;
      i_pl_data  = (idx < pl.size()) ? pl[idx] : 8'hAA;
      i_tx_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      i_start    = poke && (c == 5);
      i_len      = (poke && c == 5) ? 8'd0 : 8'(pl.size());
      @(negedge clk);
      take = i_pl_valid && o_pl_ready;
      @(posedge clk); #1;
      if (take) idx++;
    end
    i_pl_valid = 1'b0; i_tx_ready = 1'b1; i_start = 1'b0;
    if (stop_after == 0) begin
      if (done_cnt == base) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: got no o_done, expected one within 3000 cycles");
      end
      chk("model_drained", exp_q.size(), 0);
      chk("payload_used", idx, pl.size());
    end
  endtask

  task automatic reject(input logic [7:0] len);
    i_start = 1'b1; i_node = 8'h01; i_len = len;
    @(posedge clk); #1;
    i_start = 1'b0; err_exp = 1'b1;
    @(posedge clk); #1;
    err_exp = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reject_tx_valid", o_tx_valid, 0);
      chk("reject_busy", o_busy, 0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_tx_valid"}, o_tx_valid, 0);
    chk({nm, "_tx_data"}, o_tx_data, 8'h00);
    chk({nm, "_pl_ready"}, o_pl_ready, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_err"}, o_err, 0);
    chk({nm, "_start_ready"}, o_start_ready, 1);
  endtask

  initial begin
    bq_t pl;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    pl = '{8'h10, 8'h20};
    cmp6("model_basic", model_pkt(8'h01, pl), lit_basic);
    pl = '{8'hE0};
    cmp6("model_esc", model_pkt(8'h01, pl), lit_esc);
    pl = '{8'hCD};
    cmp6("model_sumesc", model_pkt(8'h01, pl), lit_sumesc);

    pl = '{8'h10, 8'h20};
    send_pkt(8'h01, pl, 0, 0, 0, 0);
    cmp6("basic", cap_q, lit_basic);
    pl = '{8'hE0};
    send_pkt(8'h01, pl, 0, 0, 0, 0);
    cmp6("pl_esc", cap_q, lit_esc);
    pl = '{8'hCD};
    send_pkt(8'h01, pl, 0, 0, 0, 0);
    cmp6("sum_esc", cap_q, lit_sumesc);

    pl = '{8'hD0, 8'hE0, 8'h01};
    send_pkt(8'hD0, pl, 0, 0, 0, 0);

    reject(8'd0);
    reject(8'd255);

    pl = '{8'h10, 8'h20};
    send_pkt(8'h01, pl, 1, 1, 1, 0);
    cmp6("backpressure", cap_q, lit_basic);
    pl = '{8'h05, 8'hE0, 8'hD0, 8'hFF, 8'h7A};
    send_pkt(8'hE0, pl, 1, 1, 0, 0);

    pl = '{8'h10, 8'h20};
    send_pkt(8'h01, pl, 0, 0, 0, 3);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_pkt(8'h01, pl, 0, 0, 0, 0);
    cmp6("after_reset", cap_q, lit_basic);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jvs_tx_framer.md
# jvs_tx_framer

Builds complete JVS packets from a node address, a payload length and a payload byte stream, and sends them one byte at a time over a valid/ready link to the UART transmitter that drives the RS-485 line. It adds the sync byte, the length byte, byte stuffing and the checksum, so the debugger's command logic only supplies raw payload. It sits directly upstream of the UART transmitter. Its output handshake follows the transmitter's contract: a byte transfers in a cycle where `o_tx_valid` and `i_tx_ready` are both high.

## Interface
Parameters:
- `MAX_PAYLOAD`, default 254. Largest accepted `i_len`. Legal range is 1..254, so that the LEN field `i_len`+1 fits in 8 bits.

Ports:
- `clk` in 1. Single clock.
- `rst` in 1. Reset, asynchronous, active-high.
- `i_start` in 1. Request a new packet; accepted only while `o_start_ready`=1.
- `i_node` in 8. Destination node address, sampled with `i_start`.
- `i_len` in 8. Payload byte count N, sampled with `i_start`.
- `o_start_ready` out 1. High in IDLE only.
- `i_pl_valid` in 1. Payload byte available.
- `i_pl_data` in 8. Payload byte.
- `o_pl_ready` out 1. Framer consumes `i_pl_data` in a cycle where `i_pl_valid` and `o_pl_ready` are both high.
- `o_tx_valid` out 1. Output byte slot full.
- `o_tx_data` out 8. Line byte presented to the UART.
- `i_tx_ready` in 1. UART ready (idle).
- `o_busy` out 1. High in any state other than IDLE.
- `o_done` out 1. One-cycle pulse when the final checksum byte (or its escape byte) transfers.
- `o_err` out 1. One-cycle pulse when a start request is rejected.

## Operation
- **Packet format on the line:** SYNC(0xE0), NODE, LEN=N+1, D0..DN-1, SUM.
  - SUM = (NODE+LEN+ΣD) mod 256, an 8-bit wrapping add.
  - SUM is computed over unescaped values.
- **Escaping:**
  - Applies to every byte after SYNC, including NODE, LEN and SUM.
  - A value 0xE0 or 0xD0 is sent as MARK(0xD0) followed by value−1 (0xDF or 0xCF).
  - SYNC itself is never escaped.
- **FSM states and transitions:** IDLE → SYNC → NODE → LEN → DATA → SUM → IDLE, plus ESC.
  - ESC emits the held escape byte, then returns to the saved next state.
- **Start request:**
  - `i_start` in IDLE with 1 ≤ `i_len` ≤ MAX_PAYLOAD: latch node and len, clear the checksum accumulator, go to SYNC.
  - Out-of-range `i_len` (0 or >MAX_PAYLOAD): pulse `o_err` the next cycle, stay in IDLE, emit nothing.
- **Output slot:**
  - When a byte is loaded into the slot, `o_tx_valid` rises.
  - On handshake, the slot empties and `o_tx_valid`=0 for exactly one cycle.
  - The FSM loads the next byte in that empty cycle, so it is valid on the following cycle.
- **Payload consumption:**
  - `o_pl_ready`=1 only in DATA with the slot empty and no escape pending.
  - On payload acceptance the byte is loaded into the slot, added to SUM, and the remaining count is decremented.
  - When the count reaches 0, the next state is SUM.
- **Payload underflow:** if `i_pl_valid` is low, the framer waits indefinitely. There is no timeout.
- **Surplus payload:** payload bytes beyond N are not consumed.
- **`i_start` while busy:** ignored, and `o_err` is not pulsed.

## Timing
- **Reset values:**
  - `o_tx_valid`=0, `o_tx_data`=0x00, `o_pl_ready`=0, `o_busy`=0, `o_done`=0, `o_err`=0, `o_start_ready`=1.
  - Internal checksum and count registers are 0.
- **Start latency:**
  - `i_start` accepted at cycle 0.
  - `o_busy`=1 and `o_start_ready`=0 at cycle 1.
  - `o_tx_valid`=1 with 0xE0 at cycle 1.
- **Byte pacing:** the interval from handshake to the next valid is 2 cycles for every byte, including escape pairs. UART backpressure may stretch any byte arbitrarily.
- **Holding rule:** while `o_tx_valid`=1 and `i_tx_ready`=0, `o_tx_data` must not change.
- **`o_done` timing:** `o_done` asserts the cycle after the last handshake. IDLE, and therefore `o_start_ready`=1, is reached in that same cycle.
- **Back-to-back packets:** the earliest back-to-back `i_start` is that cycle.
- **Reset mid-packet:** asynchronous return to the reset values. A partial packet is abandoned, and the next packet starts with SYNC, which resynchronises the receiver.

## Structure
- Shared package `jvs_pkg` holds:
  - `JVS_SYNC`=8'hE0 and `JVS_MARK`=8'hD0.
  - The `jvs_tx_state_t` enum.
  - A function `jvs_needs_esc(byte)`.
- These are shared with the planned RX deframer.
- No sub-module. A payload FIFO, if needed, is instantiated by the parent, not inside this block.

## Test plan
- **Basic packet:** node 0x01, len 2, payload 0x10 0x20, `i_tx_ready` always 1 → line bytes E0 01 03 10 20 34; one `o_done` pulse.
- **Payload escape:** node 0x01, len 1, payload 0xE0 → E0 01 02 D0 DF E3.
- **SUM escape:** node 0x01, len 1, payload 0xCD → SUM=0xD0 → E0 01 02 CD D0 CF.
- **Rejection:**
  - `i_len`=0 → `o_err` pulse, `o_tx_valid` stays 0.
  - `i_len`=255 → same response.
- **Backpressure:** basic packet with `i_tx_ready` randomly low and `i_pl_valid` gaps → identical byte sequence, and `o_tx_data` stable while stalled.
- **Reset mid-packet:** assert `rst` after the LEN byte transfers → outputs return to reset values immediately; a new basic packet afterwards is emitted correctly.
